// File: rtl/capsense_scan_ctrl.sv
// capsense_scan_ctrl
//   Paces a capacitive-touch sampler and debounces its per-button results.
//   A free-running divider makes the sampler's rate strobe, a period counter
//   launches scans, and each completed scan feeds one debounce lane per
//   button. Debounced changes are queued as pending bits and handed out one
//   at a time, lowest index first, on a valid/ready event port.
//
// Ports
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   ena_o        one-clock sampling-rate strobe (every ENA_DIV clocks)
//   start_o      one-clock scan request to the sampler
//   oe_i         sampler idle (1) / scanning (0)
//   sampled_i    per-button raw result, 1 = touched
//   state_o      debounced button state, 1 = pressed
//   evt_valid_o  event available
//   evt_ready_i  consumer accepts event
//   evt_idx_o    button index of the event
//   evt_press_o  1 = press, 0 = release
//   tmo_o        sticky: a scan ran for TMO or more rate strobes
//   ovf_o        sticky: a button changed again before its event was taken

// One debounce lane: counts consecutive scans that disagree with the
// accepted state and flips the state after DEB of them.
module capsense_btn_lane #(
  parameter int DEB = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_upd,
  input  logic i_samp,
  output logic o_state,
  output logic o_tog
);
  logic [3:0] r_cnt;
  logic       r_state;

  assign o_state = r_state;
  assign o_tog   = i_upd && (i_samp != r_state) && (r_cnt == 4'(DEB - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (i_upd) begin
      if (i_samp == r_state) begin
        r_cnt <= '0;
      end else if (o_tog) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else if (r_cnt != 4'(DEB)) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
endmodule

module capsense_scan_ctrl #(
  parameter int N       = 4,
  parameter int ENA_DIV = 16,
  parameter int PERIOD  = 4096,
  parameter int DEB     = 3,
  parameter int TMO     = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  output logic                                ena_o,
  output logic                                start_o,
  input  logic                                oe_i,
  input  logic [N-1:0]                        sampled_i,
  output logic [N-1:0]                        state_o,
  output logic                                evt_valid_o,
  input  logic                                evt_ready_i,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] evt_idx_o,
  output logic                                evt_press_o,
  output logic                                tmo_o,
  output logic                                ovf_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(ENA_DIV);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_UPDATE
  } state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_div;
  logic            r_ena;
  logic [PW-1:0]   r_per;
  logic            w_req;
  logic            r_bcnt;
  logic [TW-1:0]   r_tcnt;
  logic [N-1:0]    r_samp;
  logic            w_upd;
  logic [N-1:0]    w_tog;
  logic [N-1:0]    r_pend;
  logic [N-1:0]    w_clr;
  logic [IW-1:0]   w_sel;
  logic            w_load;
  logic            r_evt_valid;
  logic [IW-1:0]   r_evt_idx;
  logic            r_evt_press;
  logic            r_tmo;
  logic            r_ovf;

  assign ena_o       = r_ena;
  assign evt_valid_o = r_evt_valid;
  assign evt_idx_o   = r_evt_idx;
  assign evt_press_o = r_evt_press;
  assign tmo_o       = r_tmo;
  assign ovf_o       = r_ovf;

  // Request is combinational off the terminal count so START is entered
  // exactly PERIOD clocks after reset release. Only IDLE consumes it, so a
  // request landing mid-scan is simply lost.
  assign w_req = (r_per == PW'(PERIOD - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_div <= '0;
      r_ena <= 1'b0;
      r_per <= '0;
    end else begin
      r_ena <= (r_div == DW'(ENA_DIV - 1));
      r_div <= (r_div == DW'(ENA_DIV - 1)) ? '0 : r_div + DW'(1);
      r_per <= w_req ? '0 : r_per + PW'(1);
    end
  end

  always_comb begin
    w_next  = r_state;
    start_o = 1'b0;
    w_upd   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_req) w_next = S_START;
      S_START: begin
        start_o = 1'b1;
        w_next  = S_WAIT_BUSY;
      end
      // Sampler never acknowledged: after two idle clocks, ask again.
      S_WAIT_BUSY: if (!oe_i)      w_next = S_WAIT_DONE;
                   else if (r_bcnt) w_next = S_START;
      S_WAIT_DONE: if (oe_i) w_next = S_UPDATE;
      S_UPDATE: begin
        w_upd  = 1'b1;
        w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_bcnt  <= 1'b0;
      r_tcnt  <= '0;
      r_samp  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_START)                     r_bcnt <= 1'b0;
      else if (r_state == S_WAIT_BUSY && oe_i)    r_bcnt <= 1'b1;
      // Timeout only flags; the sampler cannot be aborted, so we keep
      // waiting and still use the result.
      if (r_state == S_START) begin
        r_tcnt <= '0;
      end else if (r_state == S_WAIT_DONE && r_ena) begin
        if (r_tcnt == TW'(TMO - 1)) begin
          r_tcnt <= '0;
          r_tmo  <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
      if (r_state == S_WAIT_DONE && oe_i) r_samp <= sampled_i;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    capsense_btn_lane #(.DEB(DEB)) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_upd   (w_upd),
      .i_samp  (r_samp[g]),
      .o_state (state_o[g]),
      .o_tog   (w_tog[g])
    );
  end

  // Lowest-index pending button wins.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel = IW'(i);
    end
    w_load = !r_evt_valid && (|r_pend);
    w_clr  = '0;
    if (w_load) w_clr[w_sel] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pend      <= '0;
      r_evt_valid <= 1'b0;
      r_evt_idx   <= '0;
      r_evt_press <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // A toggle on the bit being loaded this clock re-arms it rather than
      // colliding with it, so it is neither lost nor an overrun.
      r_pend <= (r_pend & ~w_clr) | w_tog;
      if (|(w_tog & r_pend & ~w_clr)) r_ovf <= 1'b1;
      if (w_load) begin
        r_evt_valid <= 1'b1;
        r_evt_idx   <= w_sel;
        r_evt_press <= state_o[w_sel];
      end else if (r_evt_valid && evt_ready_i) begin
        r_evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_capsense_scan_ctrl.sv
module tb_capsense_scan_ctrl;
  localparam int N = 4, ENA_DIV = 4, PERIOD = 64, DEB = 3, TMO = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         oe_i = 1'b1;
  logic         evt_ready_i = 1'b1;
  logic [N-1:0] sampled_i = '0;
  logic         ena_o, start_o, evt_valid_o, evt_press_o, tmo_o, ovf_o;
  logic [N-1:0] state_o;
  logic [1:0]   evt_idx_o;

  always #5 clk_i = ~clk_i;

  capsense_scan_ctrl #(.N(N), .ENA_DIV(ENA_DIV), .PERIOD(PERIOD), .DEB(DEB), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ena_o(ena_o), .start_o(start_o), .oe_i(oe_i),
    .sampled_i(sampled_i), .state_o(state_o), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i), .evt_idx_o(evt_idx_o), .evt_press_o(evt_press_o),
    .tmo_o(tmo_o), .ovf_o(ovf_o)
  );

  int checks = 0;
  int errors = 0;

  // Scan-level reference: accepted state, disagree count per button,
  // expected event stream.
  typedef struct { int idx; int press; } evt_t;
  logic [N-1:0] mst = '0;
  int           mcnt[N];
  evt_t         q[$];
  logic         exp_ovf = 1'b0;
  logic         exp_tmo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_reset();
    mst = '0;
    for (int b = 0; b < N; b++) mcnt[b] = 0;
    q.delete();
    exp_ovf = 1'b0;
    exp_tmo = 1'b0;
  endtask

  task automatic model_scan(input logic [N-1:0] s);
    for (int b = 0; b < N; b++) begin
      if (s[b] == mst[b]) mcnt[b] = 0;
      else begin
        mcnt[b]++;
        if (mcnt[b] == DEB) begin
          mst[b]  = ~mst[b];
          mcnt[b] = 0;
          q.push_back('{idx: b, press: int'(mst[b])});
        end
      end
    end
  endtask

  task automatic wait_start();
    int k = 0;
    @(negedge clk_i);
    while (!start_o && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    if (!start_o) fail_now("wait_start");
  endtask

  task automatic drain_events();
    int   k = 0;
    evt_t e;
    while ((q.size() > 0 || evt_valid_o) && k < 60) begin
      if (evt_valid_o && evt_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL spurious_evt observed=idx%0d expected=none", evt_idx_o);
        end else begin
          e = q.pop_front();
          chk("evt_idx", 32'(evt_idx_o), 32'(e.idx));
          chk("evt_press", 32'(evt_press_o), 32'(e.press));
        end
      end
      @(negedge clk_i);
      k++;
    end
    if (k >= 60) fail_now("drain");
  endtask

  // Sampler finishes: present result with oe_i rising, then check after UPDATE.
  task automatic complete_scan(input logic [N-1:0] s, input bit drain);
    sampled_i = s;
    oe_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    model_scan(s);
    chk("state_o", 32'(state_o), 32'(mst));
    chk("ovf_o", 32'(ovf_o), 32'(exp_ovf));
    chk("tmo_o", 32'(tmo_o), 32'(exp_tmo));
    if (drain) drain_events();
  endtask

  // Called at the negedge where start_o is seen.
  task automatic finish_scan(input logic [N-1:0] s, input int dly, input int len, input bit drain);
    repeat (dly) @(negedge clk_i);
    oe_i = 1'b0;
    repeat (len) @(negedge clk_i);
    complete_scan(s, drain);
  endtask

  task automatic do_scan(input logic [N-1:0] s, input bit drain);
    wait_start();
    finish_scan(s, int'($urandom_range(2)), int'($urandom_range(10, 2)), drain);
  endtask

  initial begin
    logic [N-1:0] tgt, s;
    int           pulses, k, starts, first_ena;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_idx", 32'(evt_idx_o), 0);
    chk("rst_press", 32'(evt_press_o), 0);
    chk("rst_ena", 32'(ena_o), 0);
    chk("rst_start", 32'(start_o), 0);
    chk("rst_tmo", 32'(tmo_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    rst_ni = 1'b1;

    // Button 1 held for DEB scans: state changes only on the third.
    do_scan(4'b0010, 1'b1);
    chk("s1_scan1", 32'(state_o), 32'h0);
    do_scan(4'b0010, 1'b1);
    chk("s1_scan2", 32'(state_o), 32'h0);
    do_scan(4'b0010, 1'b1);
    chk("s1_scan3", 32'(state_o), 32'h2);

    // Button 0 chatters every scan: never accepted.
    for (int i = 0; i < 4; i++) do_scan((i % 2 == 0) ? 4'b0011 : 4'b0010, 1'b1);
    chk("s2_state", 32'(state_o), 32'h2);

    // Sampler ignores the first request: start is re-issued after 2 clocks.
    wait_start();
    @(negedge clk_i);
    chk("reissue_gap1", 32'(start_o), 0);
    @(negedge clk_i);
    chk("reissue_gap2", 32'(start_o), 0);
    @(negedge clk_i);
    chk("reissue_start", 32'(start_o), 1);
    finish_scan(4'b0010, 0, 4, 1'b1);

    // Buttons 0 and 3 accepted together while the consumer stalls.
    evt_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_scan(4'b1011, 1'b0);
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      chk("s3_hold_valid", 32'(evt_valid_o), 1);
      chk("s3_hold_idx", 32'(evt_idx_o), 0);
      chk("s3_hold_press", 32'(evt_press_o), 1);
      @(negedge clk_i);
    end
    evt_ready_i = 1'b1;
    drain_events();

    // Button 0 release occupies the event slot; button 2 is then pressed
    // and released with both changes stuck behind it.
    evt_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_scan(4'b1010, 1'b0);
    for (int i = 0; i < 3; i++) do_scan(4'b1110, 1'b0);
    chk("s4_no_ovf_yet", 32'(ovf_o), 0);
    do_scan(4'b1010, 1'b0);
    do_scan(4'b1010, 1'b0);
    exp_ovf = 1'b1;  // this release re-sets button 2's still-pending bit
    do_scan(4'b1010, 1'b0);
    // Pending press and release of button 2 collapse into one event that
    // reports the current (released) state.
    q.delete();
    q.push_back('{idx: 0, press: 0});
    q.push_back('{idx: 2, press: 0});
    evt_ready_i = 1'b1;
    drain_events();

    // Timeout: third agreeing scan on button 2 is the stuck one; its result
    // must still be applied.
    do_scan(4'b1110, 1'b1);
    do_scan(4'b1110, 1'b1);
    wait_start();
    oe_i = 1'b0;
    @(negedge clk_i);
    pulses = 0;
    k = 0;
    while (pulses < TMO && k < 100) begin
      @(negedge clk_i);
      k++;
      if (ena_o) pulses++;
    end
    if (pulses < TMO) fail_now("tmo_pulses");
    chk("tmo_before", 32'(tmo_o), 0);
    @(negedge clk_i);
    chk("tmo_after", 32'(tmo_o), 1);
    exp_tmo = 1'b1;
    starts = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk_i);
      if (start_o) starts++;
    end
    chk("tmo_no_start", 32'(starts), 0);
    complete_scan(4'b1110, 1'b1);
    chk("tmo_state", 32'(state_o), 32'hE);
    do_scan(4'b1110, 1'b1);

    // Reset in the middle of a scan.
    wait_start();
    oe_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_valid", 32'(evt_valid_o), 0);
    chk("mid_rst_idx", 32'(evt_idx_o), 0);
    chk("mid_rst_press", 32'(evt_press_o), 0);
    chk("mid_rst_ena", 32'(ena_o), 0);
    chk("mid_rst_start", 32'(start_o), 0);
    chk("mid_rst_tmo", 32'(tmo_o), 0);
    chk("mid_rst_ovf", 32'(ovf_o), 0);
    rst_ni = 1'b1;
    oe_i = 1'b1;
    model_reset();
    k = 0;
    first_ena = -1;
    while (!start_o && k < PERIOD + 10) begin
      @(negedge clk_i);
      k++;
      if (ena_o && first_ena < 0) first_ena = k;
    end
    chk("rel_start_delay", 32'(k), 32'(PERIOD));
    chk("rel_ena_delay", 32'(first_ena), 32'(ENA_DIV));
    finish_scan(4'b0000, 0, 3, 1'b1);

    // Randomized scans against the scan-level model.
    tgt = '0;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(3) == 0) tgt = N'($urandom);
      s = tgt;
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) s[b] = ~s[b];
      do_scan(s, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
